katsayi_blok_zamanlayici: RTL and testbench
===========================================

// Module: katsayi_blok_zamanlayici
// PURPOSE
//  Sequences sparse coefficients from the zigzag normalizer into complete 8x8 blocks for the inverse DCT.
//  Two ping-pong banks of 64 coefficients each; positions never written read back as zero.
//  The write side accepts (row,col,data) in any order. The read side streams all 64 in raster order.
//  Writing into one bank overlaps reading of the other. Sits between zigzag_normalizer and the IDCT stage.
// PARAMETERS
//  DATA_W    16   coefficient width; equals `HDATA_BIT
//  BLK_BIT   3    row/col index width; block side = 2**BLK_BIT = 8, fixed
// PORTS
//  clk_i           in   1       single clock, rising edge
//  rst_i           in   1       reset, asynchronous, active-high
//  ct_veri_i       in   DATA_W  coefficient value from normalizer
//  ct_row_i        in   3       coefficient row
//  ct_col_i        in   3       coefficient col
//  ct_son_i        in   1       sideband: this coefficient is the last of its block (qualified by ct_gecerli_i)
//  ct_gecerli_i    in   1       write valid
//  ct_hazir_o      out  1       write ready
//  idct_veri_o     out  DATA_W  coefficient to IDCT (0 where never written)
//  idct_row_o      out  3       raster row
//  idct_col_o      out  3       raster col
//  idct_son_o      out  1       high with the 64th coefficient (row=7,col=7)
//  idct_gecerli_o  out  1       read valid
//  idct_hazir_i    in   1       read ready
//  mesgul_o        out  1       any bank not empty, or idct_gecerli_o high
// BEHAVIOUR
//  Storage
//   - mem[2][64] x DATA_W plus mask[2][64] (bit set = written); index = {row,col}.
//   - Bank status is BOS (empty/filling) or DOLU (closed, awaiting/under read).
//   - Write pointer wb and read pointer rb, both 1 bit.
//  Reset (rst_i high, async)
//   - Masks cleared, both banks BOS, wb=rb=0, read index=0.
//   - idct_gecerli_o=0, idct_veri_o=0, idct_row_o=0, idct_col_o=0, idct_son_o=0.
//   - Partial block discarded; ct_hazir_o=1 from the first edge after release.
//  Write side
//   - ct_hazir_o = (status[wb]==BOS), purely from registers.
//   - Transfer on ct_gecerli_i && ct_hazir_o: mem[wb][idx]<=veri and mask[wb][idx]<=1.
//   - Repeated position within a block: last write wins.
//   - If ct_son_i is high on a transfer, the coefficient is written and, on the same edge, status[wb]<=DOLU and wb toggles.
//   - Both banks DOLU -> ct_hazir_o=0. Upstream holds data stable.
//  Read FSM: BOSTA -> AKIS -> BOSTA
//   - BOSTA: if status[rb]==DOLU, go to AKIS with idx=0.
//   - AKIS: output register loads when !idct_gecerli_o || idct_hazir_i.
//     Loaded values: veri = mask[rb][idx] ? mem[rb][idx] : 0; row = idx[5:3]; col = idx[2:0]; son = (idx==63).
//     idx increments on each load.
//   - When the idx=63 entry is loaded, mask[rb] is cleared, status[rb]<=BOS, rb toggles, and the FSM returns to BOSTA.
//   - idct_* outputs hold until the handshake completes (valid never drops without ready).
//  Latency and throughput
//   - Read side idle, ct_son accepted at edge E: the BOSTA->AKIS transition happens at edge E+1 and the first coefficient loads at edge E+2.
//     idct_gecerli_o is therefore high after edge E+2.
//   - With idct_hazir_i=1: one coefficient per cycle, at most 2 idle cycles between consecutive blocks.
//  Simultaneous events
//   - A write closing bank A and the read releasing bank B on the same edge both take effect.
//   - A write into a bank on the same edge it is released is impossible: ct_hazir_o=0 for that bank.
//   - No read-before-close: rb never reaches a BOS bank in AKIS.
//  Width: no arithmetic on data; idx is 6-bit and wraps 63->0 only via the release path.
// TESTING
//  1 Reset, write (0,0)=100 with son=1 -> 64 outputs in raster order, (0,0)=100, all other 0, son only on (7,7), first valid 2 cycles after accept.
//  2 Write (7,7)=-5, (3,2)=9, (3,2)=11, (0,0)=1 son -> output idx 26=11, idx 63=-5(0xFFFB), idx 0=1, others 0.
//  3 idct_hazir_i=0: three blocks back-to-back -> ct_hazir_o drops after the 2nd son. Raise ready -> all data correct, blocks in order, none lost.
//  4 Random idct_hazir_i at 50% -> outputs stable while valid&&!ready, exactly 64 transfers per block, son count == blocks sent.
//  5 Assert rst_i mid-stream (read idx=20, other bank half written) -> outputs 0 immediately, next block shows no stale nonzero coefficients.
//  6 Close bank on the same cycle read releases the other bank, ready=1 -> no stall beyond 2 idle cycles, both blocks intact.

Source files
------------

// File: rtl/katsayi_blok_zamanlayici_if.sv
// Handshake bundle between the zigzag normalizer, the block sequencer and the IDCT stage.
interface katsayi_blok_zamanlayici_if #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned BLK_BIT = 3
);
    logic [DATA_W-1:0]  ct_veri_i;
    logic [BLK_BIT-1:0] ct_row_i;
    logic [BLK_BIT-1:0] ct_col_i;
    logic               ct_son_i;
    logic               ct_gecerli_i;
    logic               ct_hazir_o;

    logic [DATA_W-1:0]  idct_veri_o;
    logic [BLK_BIT-1:0] idct_row_o;
    logic [BLK_BIT-1:0] idct_col_o;
    logic               idct_son_o;
    logic               idct_gecerli_o;
    logic               idct_hazir_i;

    logic               mesgul_o;

    modport slave (
        input  ct_veri_i, ct_row_i, ct_col_i, ct_son_i, ct_gecerli_i, idct_hazir_i,
        output ct_hazir_o, idct_veri_o, idct_row_o, idct_col_o, idct_son_o,
               idct_gecerli_o, mesgul_o
    );

    modport master (
        output ct_veri_i, ct_row_i, ct_col_i, ct_son_i, ct_gecerli_i, idct_hazir_i,
        input  ct_hazir_o, idct_veri_o, idct_row_o, idct_col_o, idct_son_o,
               idct_gecerli_o, mesgul_o
    );
endinterface

// File: rtl/katsayi_blok_zamanlayici.sv
// Ping-pong 8x8 coefficient block buffer: sparse random-order writes in, full raster-order blocks out.
module katsayi_blok_zamanlayici #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned BLK_BIT = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    katsayi_blok_zamanlayici_if.slave bus
);
    localparam int unsigned IDX_W    = 2 * BLK_BIT;
    localparam int unsigned DERINLIK = 1 << IDX_W;
    localparam logic [IDX_W-1:0] SON_IDX = IDX_W'(DERINLIK - 1);

    typedef enum logic { BOS = 1'b0, DOLU = 1'b1 } banka_t;
    typedef enum logic { BOSTA = 1'b0, AKIS = 1'b1 } oku_t;

    logic [DATA_W-1:0]   mem_q  [2][DERINLIK];
    logic [DERINLIK-1:0] mask_q [2];
    banka_t              banka_q [2];
    banka_t              banka_n [2];
    logic [1:0]          yazildi_q;
    logic [1:0]          yazildi_n;
    logic                wb_q, wb_n, rb_q;
    logic [IDX_W-1:0]    idx_q;
    oku_t                durum_q;

    logic [DATA_W-1:0]   veri_q;
    logic [BLK_BIT-1:0]  row_q, col_q;
    logic                son_q, gecerli_q, gecerli_n, hazir_q, mesgul_q;

    logic [IDX_W-1:0]    wr_idx_c;
    logic [DATA_W-1:0]   oku_veri_c;
    logic                yaz_c, kapat_c, yukle_c, birak_c;

    assign wr_idx_c   = {bus.ct_row_i, bus.ct_col_i};
    assign yaz_c      = bus.ct_gecerli_i && hazir_q;
    assign kapat_c    = yaz_c && bus.ct_son_i;
    assign yukle_c    = (durum_q == AKIS) && (!gecerli_q || bus.idct_hazir_i);
    assign birak_c    = yukle_c && (idx_q == SON_IDX);
    // Never-written positions read as zero so stale data from earlier blocks cannot leak.
    assign oku_veri_c = mask_q[rb_q][idx_q] ? mem_q[rb_q][idx_q] : '0;

    // Bank bookkeeping for this edge; close and release always hit different banks.
    always_comb begin
        banka_n[0] = banka_q[0];
        banka_n[1] = banka_q[1];
        yazildi_n  = yazildi_q;
        if (yaz_c)   yazildi_n[wb_q] = 1'b1;
        if (kapat_c) banka_n[wb_q]   = DOLU;
        if (birak_c) begin
            banka_n[rb_q]   = BOS;
            yazildi_n[rb_q] = 1'b0;
        end
        wb_n      = wb_q ^ kapat_c;
        gecerli_n = yukle_c || (gecerli_q && !bus.idct_hazir_i);
    end

    // Coefficient storage; validity is tracked by the mask, so no reset is needed here.
    always_ff @(posedge clk_i) begin
        if (yaz_c) mem_q[wb_q][wr_idx_c] <= bus.ct_veri_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask_q[0]  <= '0;
            mask_q[1]  <= '0;
            banka_q[0] <= BOS;
            banka_q[1] <= BOS;
            yazildi_q  <= '0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            idx_q      <= '0;
            durum_q    <= BOSTA;
            veri_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            son_q      <= 1'b0;
            gecerli_q  <= 1'b0;
            hazir_q    <= 1'b1;
            mesgul_q   <= 1'b0;
        end else begin
            banka_q[0] <= banka_n[0];
            banka_q[1] <= banka_n[1];
            yazildi_q  <= yazildi_n;
            wb_q       <= wb_n;
            rb_q       <= rb_q ^ birak_c;
            gecerli_q  <= gecerli_n;
            hazir_q    <= (banka_n[wb_n] == BOS);
            mesgul_q   <= (|yazildi_n) || gecerli_n;

            if (birak_c) mask_q[rb_q] <= '0;
            if (yaz_c)   mask_q[wb_q][wr_idx_c] <= 1'b1;

            case (durum_q)
                BOSTA: begin
                    if (banka_q[rb_q] == DOLU) begin
                        durum_q <= AKIS;
                        idx_q   <= '0;
                    end
                end
                AKIS: begin
                    if (yukle_c) begin
                        veri_q <= oku_veri_c;
                        row_q  <= idx_q[IDX_W-1:BLK_BIT];
                        col_q  <= idx_q[BLK_BIT-1:0];
                        son_q  <= (idx_q == SON_IDX);
                        idx_q  <= IDX_W'(idx_q + 1'b1);
                        if (birak_c) durum_q <= BOSTA;
                    end
                end
            endcase
        end
    end

    assign bus.ct_hazir_o     = hazir_q;
    assign bus.idct_veri_o    = veri_q;
    assign bus.idct_row_o     = row_q;
    assign bus.idct_col_o     = col_q;
    assign bus.idct_son_o     = son_q;
    assign bus.idct_gecerli_o = gecerli_q;
    assign bus.mesgul_o       = mesgul_q;
endmodule

// File: tb/tb_katsayi_blok_zamanlayici.sv
// Scoreboard bench for the ping-pong coefficient block sequencer.
module tb_katsayi_blok_zamanlayici;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    katsayi_blok_zamanlayici_if #(.DATA_W(16), .BLK_BIT(3)) bus ();

    katsayi_blok_zamanlayici #(.DATA_W(16), .BLK_BIT(3)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0]  row;
        logic [2:0]  col;
        logic [15:0] veri;
        logic        son;
    } cikis_t;

    typedef struct packed {
        logic [2:0]  row;
        logic [2:0]  col;
        logic [15:0] veri;
    } yazma_t;

    int     checks = 0;
    int     errors = 0;
    int     transfer_sayisi = 0;
    int     son_sayisi = 0;
    bit     rastgele = 1'b0;
    bit     tikali = 1'b0;
    cikis_t sb[$];
    yazma_t yq[$];
    cikis_t mon_cur, mon_tut, mon_exp;

    // Output monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
    always @(negedge clk_i) begin
        if (rst_i) begin
            tikali = 1'b0;
        end else begin
            mon_cur = {bus.idct_row_o, bus.idct_col_o, bus.idct_veri_o, bus.idct_son_o};
            if (tikali) begin
                checks++;
                if (mon_cur !== mon_tut) begin
                    errors++;
                    $display("FAIL hold_stable: got %h required %h", mon_cur, mon_tut);
                end
            end
            tikali  = bus.idct_gecerli_o && !bus.idct_hazir_i;
            mon_tut = mon_cur;
            if (bus.idct_gecerli_o && bus.idct_hazir_i) begin
                transfer_sayisi++;
                if (bus.idct_son_o) son_sayisi++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h required none", mon_cur);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_cur !== mon_exp) begin
                        errors++;
                        $display("FAIL output r%0d c%0d: got %h required %h",
                                 mon_exp.row, mon_exp.col, mon_cur, mon_exp);
                    end
                end
            end
        end
    end

    always @(posedge clk_i) begin
        if (rastgele) begin
            #1 bus.idct_hazir_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic yaz(input logic [2:0] r, input logic [2:0] c,
                       input logic [15:0] v, input logic s);
        int t = 0;
        @(negedge clk_i);
        bus.ct_row_i     = r;
        bus.ct_col_i     = c;
        bus.ct_veri_i    = v;
        bus.ct_son_i     = s;
        bus.ct_gecerli_i = 1'b1;
        while (!bus.ct_hazir_o && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        if (!bus.ct_hazir_o) begin
            checks++;
            errors++;
            $display("FAIL write_timeout: ct_hazir_o got 0 required 1");
            bus.ct_gecerli_i = 1'b0;
        end else begin
            @(posedge clk_i);
            #1;
            bus.ct_gecerli_i = 1'b0;
            bus.ct_son_i     = 1'b0;
        end
    endtask

    // Expected raster stream for the block currently in yq (last write wins, rest zero).
    task automatic beklenen_ekle();
        logic [15:0] m [64];
        logic [5:0]  ii;
        for (int i = 0; i < 64; i++) m[i] = 16'h0;
        foreach (yq[k]) m[{yq[k].row, yq[k].col}] = yq[k].veri;
        for (int i = 0; i < 64; i++) begin
            ii = 6'(i);
            sb.push_back('{row: ii[5:3], col: ii[2:0], veri: m[i], son: (i == 63)});
        end
    endtask

    task automatic gonder();
        yazma_t w[$];
        w = yq;
        foreach (w[k]) yaz(w[k].row, w[k].col, w[k].veri, 1'(k == w.size() - 1));
    endtask

    task automatic rastgele_blok(input int n);
        yq.delete();
        for (int i = 0; i < n; i++)
            yq.push_back('{row: 3'($urandom_range(0, 7)), col: 3'($urandom_range(0, 7)),
                           veri: 16'($urandom)});
    endtask

    task automatic bekle_bos(input int budget);
        int t = 0;
        while ((sb.size() != 0 || bus.idct_gecerli_o) && t < budget) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        checks++;
        if (sb.size() != 0 || bus.idct_gecerli_o) begin
            errors++;
            $display("FAIL drain: remaining %0d required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        bus.ct_veri_i = '0; bus.ct_row_i = '0; bus.ct_col_i = '0;
        bus.ct_son_i = 1'b0; bus.ct_gecerli_i = 1'b0; bus.idct_hazir_i = 1'b1;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({bus.idct_gecerli_o, bus.idct_veri_o, bus.idct_row_o, bus.idct_col_o,
             bus.idct_son_o} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %b%h%h%h%b required 0", bus.idct_gecerli_o,
                     bus.idct_veri_o, bus.idct_row_o, bus.idct_col_o, bus.idct_son_o);
        end
        checks++;
        if (bus.mesgul_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mesgul: got %b required 0", bus.mesgul_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        checks++;
        if (bus.ct_hazir_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_hazir: got %b required 1", bus.ct_hazir_o);
        end
    endtask

    task automatic test_tek_katsayi();
        bus.idct_hazir_i = 1'b1;
        yq.delete();
        yq.push_back('{row: 3'd0, col: 3'd0, veri: 16'd100});
        beklenen_ekle();
        yaz(3'd0, 3'd0, 16'd100, 1'b1);
        @(posedge clk_i);
        #1;
        checks++;
        if (bus.idct_gecerli_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_e1: valid got %b required 0", bus.idct_gecerli_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if ({bus.idct_gecerli_o, bus.idct_row_o, bus.idct_col_o, bus.idct_veri_o}
            !== {1'b1, 3'd0, 3'd0, 16'd100}) begin
            errors++;
            $display("FAIL latency_e2: got v%b r%0d c%0d %0d required v1 r0 c0 100",
                     bus.idct_gecerli_o, bus.idct_row_o, bus.idct_col_o, bus.idct_veri_o);
        end
        checks++;
        if (bus.mesgul_o !== 1'b1) begin
            errors++;
            $display("FAIL mesgul_busy: got %b required 1", bus.mesgul_o);
        end
        bekle_bos(200);
        checks++;
        if (bus.mesgul_o !== 1'b0) begin
            errors++;
            $display("FAIL mesgul_idle: got %b required 0", bus.mesgul_o);
        end
    endtask

    task automatic test_siralama();
        yq.delete();
        yq.push_back('{row: 3'd7, col: 3'd7, veri: 16'hFFFB});
        yq.push_back('{row: 3'd3, col: 3'd2, veri: 16'd9});
        yq.push_back('{row: 3'd3, col: 3'd2, veri: 16'd11});
        yq.push_back('{row: 3'd0, col: 3'd0, veri: 16'd1});
        beklenen_ekle();
        gonder();
        bekle_bos(200);
    endtask

    task automatic test_back_to_back();
        bus.idct_hazir_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            rastgele_blok(5);
            beklenen_ekle();
            gonder();
        end
        checks++;
        if (bus.ct_hazir_o !== 1'b0) begin
            errors++;
            $display("FAIL both_full_hazir: got %b required 0", bus.ct_hazir_o);
        end
        rastgele_blok(6);
        beklenen_ekle();
        fork
            gonder();
        join_none
        repeat (10) @(posedge clk_i);
        #1;
        checks++;
        if (bus.ct_hazir_o !== 1'b0) begin
            errors++;
            $display("FAIL stalled_hazir: got %b required 0", bus.ct_hazir_o);
        end
        bus.idct_hazir_i = 1'b1;
        wait fork;
        bekle_bos(1000);
    endtask

    task automatic test_rastgele_hazir();
        int s0 = son_sayisi;
        int t0 = transfer_sayisi;
        rastgele = 1'b1;
        for (int b = 0; b < 4; b++) begin
            rastgele_blok(8);
            beklenen_ekle();
            gonder();
        end
        bekle_bos(3000);
        rastgele = 1'b0;
        @(posedge clk_i);
        #2;
        bus.idct_hazir_i = 1'b1;
        checks++;
        if (son_sayisi - s0 !== 4) begin
            errors++;
            $display("FAIL son_count: got %0d required 4", son_sayisi - s0);
        end
        checks++;
        if (transfer_sayisi - t0 !== 256) begin
            errors++;
            $display("FAIL transfer_count: got %0d required 256", transfer_sayisi - t0);
        end
    endtask

    task automatic test_reset_akista();
        int t = 0;
        bus.idct_hazir_i = 1'b0;
        rastgele_blok(12);
        beklenen_ekle();
        gonder();
        for (int i = 0; i < 32; i++) yaz(3'(i / 8), 3'(i % 8), 16'(i + 1), 1'b0);
        bus.idct_hazir_i = 1'b1;
        while (!(bus.idct_gecerli_o && bus.idct_row_o == 3'd2 && bus.idct_col_o == 3'd4)
               && t < 500) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        checks++;
        if (!(bus.idct_gecerli_o && bus.idct_row_o == 3'd2 && bus.idct_col_o == 3'd4)) begin
            errors++;
            $display("FAIL reach_idx20: got r%0d c%0d required r2 c4",
                     bus.idct_row_o, bus.idct_col_o);
        end
        sb.delete();
        rst_i = 1'b1;
        #1;
        checks++;
        if ({bus.idct_gecerli_o, bus.idct_veri_o, bus.idct_row_o, bus.idct_col_o,
             bus.idct_son_o, bus.mesgul_o} !== 25'h0) begin
            errors++;
            $display("FAIL async_reset: got v%b %h r%0d c%0d s%b m%b required all 0",
                     bus.idct_gecerli_o, bus.idct_veri_o, bus.idct_row_o,
                     bus.idct_col_o, bus.idct_son_o, bus.mesgul_o);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        yq.delete();
        yq.push_back('{row: 3'd1, col: 3'd1, veri: 16'd7});
        beklenen_ekle();
        gonder();
        bekle_bos(200);
        yq.delete();
        yq.push_back('{row: 3'd6, col: 3'd5, veri: 16'd3});
        beklenen_ekle();
        gonder();
        bekle_bos(200);
    endtask

    task automatic test_es_zamanli();
        int t = 0;
        yazma_t son_w;
        bus.idct_hazir_i = 1'b1;
        rastgele_blok(6);
        beklenen_ekle();
        gonder();
        rastgele_blok(4);
        son_w = '{row: 3'd5, col: 3'd5, veri: 16'h0055};
        yq.push_back(son_w);
        beklenen_ekle();
        for (int k = 0; k < 4; k++) yaz(yq[k].row, yq[k].col, yq[k].veri, 1'b0);
        while (!(bus.idct_gecerli_o && bus.idct_row_o == 3'd7 && bus.idct_col_o == 3'd6)
               && t < 200) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        yaz(son_w.row, son_w.col, son_w.veri, 1'b1);
        checks++;
        if ({bus.idct_gecerli_o, bus.idct_row_o, bus.idct_col_o, bus.idct_son_o}
            !== {1'b1, 3'd7, 3'd7, 1'b1}) begin
            errors++;
            $display("FAIL same_edge_last: got v%b r%0d c%0d s%b required v1 r7 c7 s1",
                     bus.idct_gecerli_o, bus.idct_row_o, bus.idct_col_o, bus.idct_son_o);
        end
        checks++;
        if (bus.ct_hazir_o !== 1'b1) begin
            errors++;
            $display("FAIL same_edge_hazir: got %b required 1", bus.ct_hazir_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (bus.idct_gecerli_o !== 1'b0) begin
            errors++;
            $display("FAIL gap_cycle: valid got %b required 0", bus.idct_gecerli_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if ({bus.idct_gecerli_o, bus.idct_row_o, bus.idct_col_o} !== {1'b1, 3'd0, 3'd0}) begin
            errors++;
            $display("FAIL next_block_start: got v%b r%0d c%0d required v1 r0 c0",
                     bus.idct_gecerli_o, bus.idct_row_o, bus.idct_col_o);
        end
        bekle_bos(200);
    endtask

    initial begin
        test_reset();
        test_tek_katsayi();
        test_siralama();
        test_back_to_back();
        test_rastgele_hazir();
        test_reset_akista();
        test_es_zamanli();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
